// File: rtl/imem_boot_loader.sv
// imem_boot_loader: turns a length-prefixed byte stream into big-endian 32-bit
// instruction-memory writes, holding the processor in start-up until the image is in.
`default_nettype none

module imem_boot_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              start_up,
  output logic              busy,
  output logic              err
);

  localparam logic [2:0] S_LEN_HI = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  localparam logic [16:0] c_MAX_WORDS = 17'(MAX_WORDS);

  logic [2:0]        state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [15:0]       idx_q, idx_d;
  logic [1:0]        bc_q, bc_d;
  logic [23:0]       word_q, word_d;
  logic              rx_ready_q, rx_ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              start_up_q, start_up_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic              w_accept;
  logic [15:0]       w_len;

  assign w_accept = rx_valid & rx_ready_q;
  assign w_len    = {n_q[15:8], rx_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LEN_HI;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    bc_d    = bc_q;
    word_d  = word_q;
    case (state_q)
      S_LEN_HI: begin
        if (w_accept) begin
          n_d[15:8] = rx_data;
          state_d   = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (w_accept) begin
          n_d[7:0] = rx_data;
          idx_d    = 16'd0;
          bc_d     = 2'd0;
          if (w_len == 16'd0) begin
            state_d = S_DONE;
          end else if ({1'b0, w_len} > c_MAX_WORDS) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_accept) begin
          word_d = {word_q[15:0], rx_data};
          bc_d   = bc_q + 2'd1;
          if (bc_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (idx_q == n_q - 16'd1) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 16'd1;
          state_d = S_DATA;
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_LEN_HI;
    endcase
  end

  // Outputs are decoded from the next state so each one is a plain flop.
  always_comb begin
    rx_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) || (state_d == S_DATA);
    we_d       = (state_d == S_WRITE);
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if (state_d == S_WRITE) begin
      addr_d  = idx_d[ADDR_W-1:0];
      wdata_d = {word_q, rx_data};
    end
    start_up_d = (state_d != S_DONE);
    busy_d     = (state_d == S_LEN_LO) || (state_d == S_DATA) || (state_d == S_WRITE);
    err_d      = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q        <= 16'd0;
      idx_q      <= 16'd0;
      bc_q       <= 2'd0;
      word_q     <= 24'd0;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      start_up_q <= 1'b1;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      n_q        <= n_d;
      idx_q      <= idx_d;
      bc_q       <= bc_d;
      word_q     <= word_d;
      rx_ready_q <= rx_ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      start_up_q <= start_up_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign start_up   = start_up_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: directed and random loads compared against a stream-parsing model.
`default_nettype none

module tb_imem_boot_loader;

  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 1024;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'd0;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              start_up;
  logic              busy;
  logic              err;

  imem_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .start_up(start_up), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [7:0]  stim[$];
  int          exp_a[$];
  logic [31:0] exp_d[$];
  int          exp_n = 0;
  bit          exp_err = 0;
  int          got_a[$];
  logic [31:0] got_d[$];
  bit          we_prev = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Reference: interpret the byte stream directly as length + big-endian words.
  task automatic model();
    int n;
    exp_a.delete();
    exp_d.delete();
    n = {stim[0], stim[1]};
    exp_err = (n > MAX_WORDS);
    exp_n = exp_err ? 0 : n;
    for (int i = 0; i < exp_n; i++) begin
      exp_a.push_back(i);
      exp_d.push_back({stim[2+4*i], stim[3+4*i], stim[4+4*i], stim[5+4*i]});
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    stim.push_back(w[31:24]);
    stim.push_back(w[23:16]);
    stim.push_back(w[15:8]);
    stim.push_back(w[7:0]);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (we_prev && exp_n > 0 && got_d.size() == exp_n) begin
        chk("start_up_fall", 64'(start_up), 64'd0);
        chk("busy_fall", 64'(busy), 64'd0);
      end
      if (imem_we) begin
        chk("ready_in_write", 64'(rx_ready), 64'd0);
        chk("start_up_in_write", 64'(start_up), 64'd1);
        got_a.push_back(int'(imem_addr));
        got_d.push_back(imem_wdata);
      end
    end
    we_prev = rst_n && imem_we;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rx_valid = 1'b0;
    got_a.delete();
    got_d.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Present stim[0..cnt-1]; a byte counts as consumed when valid and ready coincide at the edge.
  task automatic send(input int cnt, input bit rnd, input int budget);
    int i = 0;
    int c = 0;
    while (i < cnt && c < budget) begin
      @(negedge clk);
      c++;
      rx_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      rx_data = rx_valid ? stim[i] : 8'($urandom);
      if (rx_valid && rx_ready) i++;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    chk("send_in_budget", 64'(i), 64'(cnt));
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (start_up === 1'b1 && err !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("finish_in_budget", 64'(start_up === 1'b0 || err === 1'b1), 64'd1);
  endtask

  task automatic compare_writes();
    chk("write_count", 64'(got_d.size()), 64'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      chk("write_addr", 64'(got_a[i]), 64'(exp_a[i]));
      chk("write_data", 64'(got_d[i]), 64'(exp_d[i]));
    end
  endtask

  task automatic probe_idle(input int cycles);
    int rdy = 0;
    int n0 = got_d.size();
    repeat (cycles) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data = 8'($urandom);
      if (rx_ready) rdy++;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    chk("idle_ready_cycles", 64'(rdy), 64'd0);
    chk("idle_no_writes", 64'(got_d.size()), 64'(n0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
    chk({tag, "_imem_we"}, 64'(imem_we), 64'd0);
    chk({tag, "_imem_addr"}, 64'(imem_addr), 64'd0);
    chk({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
    chk({tag, "_start_up"}, 64'(start_up), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  task automatic load_basic_stream();
    stim.delete();
    stim.push_back(8'h00);
    stim.push_back(8'h02);
    push_word(32'h8C010004);
    push_word(32'h00221820);
    model();
  endtask

  initial begin
    int n;

    // Reset values, then rx_ready rising one cycle after release.
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(rx_ready), 64'd1);
    chk("busy_idle", 64'(busy), 64'd0);

    // Basic load with rx_valid held high.
    load_basic_stream();
    chk("basic_first_expected", 64'(exp_d[0]), 64'h8C010004);
    send(stim.size(), 1'b0, 100);
    wait_done(50);
    compare_writes();
    chk("basic_err", 64'(err), 64'd0);
    chk("basic_ready_done", 64'(rx_ready), 64'd0);
    probe_idle(8);

    // Same stream with random gaps.
    do_reset();
    load_basic_stream();
    send(stim.size(), 1'b1, 400);
    wait_done(50);
    compare_writes();

    // Random programs under random backpressure.
    for (int t = 0; t < 4; t++) begin
      do_reset();
      n = $urandom_range(1, 6);
      stim.delete();
      stim.push_back(8'(n >> 8));
      stim.push_back(8'(n));
      for (int w = 0; w < n; w++) push_word($urandom);
      model();
      send(stim.size(), 1'b1, 600);
      wait_done(50);
      compare_writes();
      chk("rand_start_up", 64'(start_up), 64'd0);
      chk("rand_err", 64'(err), 64'd0);
    end

    // Zero length goes straight to DONE.
    do_reset();
    stim.delete();
    stim.push_back(8'h00);
    stim.push_back(8'h00);
    model();
    send(2, 1'b0, 20);
    chk("zero_start_up", 64'(start_up), 64'd0);
    chk("zero_err", 64'(err), 64'd0);
    chk("zero_busy", 64'(busy), 64'd0);
    probe_idle(6);
    compare_writes();

    // N = 1025 is rejected.
    do_reset();
    stim.delete();
    stim.push_back(8'h04);
    stim.push_back(8'h01);
    model();
    send(2, 1'b0, 20);
    chk("over_err", 64'(err), 64'(exp_err));
    chk("over_start_up", 64'(start_up), 64'd1);
    chk("over_ready", 64'(rx_ready), 64'd0);
    chk("over_busy", 64'(busy), 64'd0);
    probe_idle(6);
    compare_writes();
    chk("over_err_sticky", 64'(err), 64'd1);

    // Full length: 1024 words, word i = i.
    do_reset();
    stim.delete();
    stim.push_back(8'h04);
    stim.push_back(8'h00);
    for (int w = 0; w < MAX_WORDS; w++) push_word(32'(w));
    model();
    send(stim.size(), 1'b0, 6000);
    wait_done(50);
    compare_writes();
    if (got_d.size() == MAX_WORDS) begin
      chk("full_last_addr", 64'(got_a[MAX_WORDS-1]), 64'd1023);
      chk("full_last_data", 64'(got_d[MAX_WORDS-1]), 64'h3FF);
    end else begin
      chk("full_write_count", 64'(got_d.size()), 64'(MAX_WORDS));
    end
    chk("full_err", 64'(err), 64'd0);
    probe_idle(8);

    // Reset after the third byte of word 1, then a fresh one-word load.
    do_reset();
    load_basic_stream();
    send(9, 1'b0, 40);
    chk("mid_words_before_reset", 64'(got_d.size()), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    got_a.delete();
    got_d.delete();
    exp_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stim.delete();
    stim.push_back(8'h00);
    stim.push_back(8'h01);
    push_word($urandom);
    model();
    send(stim.size(), 1'b1, 200);
    wait_done(50);
    compare_writes();
    chk("mid_start_up", 64'(start_up), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
